fp_sqrt_arbiter: RTL and testbench
==================================

Name: fp_sqrt_arbiter

Overview:
- Shares one multi-cycle, non-pipelined FP square-root unit between NUM_REQ requesters, such as per-lane or per-warp FPU issue slots.
- Arbitrates requests round-robin and issues one operation at a time.
- Holds the requester's tag while the unit iterates, then returns the 32-bit result and tag to the granted requester with a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TAG_W, 6, width of the opaque per-request tag returned unchanged
- DATA_WIDTH, 32, operand/result width (IEEE 754 single)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_operand  in  NUM_REQ*DATA_WIDTH  packed operands; requester i at [i*32 +: 32]
- req_tag  in  NUM_REQ*TAG_W  packed tags
- resp_valid  out  NUM_REQ  one-hot response valid to the owning requester
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_result  out  DATA_WIDTH  sqrt result, shared bus
- resp_tag  out  TAG_W  tag of the completed request, shared bus
- sqrt_start  out  1  one-cycle start pulse to the sqrt unit
- sqrt_operand  out  DATA_WIDTH  operand to the sqrt unit; held stable from start until sqrt_valid
- sqrt_result  in  DATA_WIDTH  unit result
- sqrt_valid  in  1  one-cycle result strobe from the unit
- sqrt_busy  in  1  unit busy; low in its idle and done states

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, captured operand/tag/result 0.
- States:
  - IDLE: req_ready is high only for the requester selected by the round-robin search, starting at the pointer, and only when sqrt_busy = 0.
    - On req_valid[g] & req_ready[g]: latch operand, tag and grant index g; set pointer = (g+1) mod NUM_REQ; go to ISSUE.
  - ISSUE: sqrt_start = 1 for exactly this one cycle, with sqrt_operand = latched operand; go to WAIT.
  - WAIT: on sqrt_valid, latch sqrt_result; go to RESP. Remain in WAIT indefinitely otherwise; no timeout.
  - RESP: resp_valid[g] = 1; resp_result and resp_tag driven from registers and stable until the handshake.
    - On resp_ready[g]: go to IDLE.
    - resp_ready on other bits is ignored.
- Latency:
  - Accept at cycle t.
  - sqrt_start at t+1.
  - resp_valid asserted the cycle after sqrt_valid.
  - Minimum gap between consecutive accepts = unit latency + 3 cycles.
- Data handling:
  - Exactly one operation is outstanding.
  - The result passes through bit-exact; the arbiter does no special-value handling.
- Arbitration rules:
  - Requesters whose req_valid is low are skipped.
  - If no req_valid is high, req_ready = 0 and the pointer is unchanged.
  - req_ready is combinational from req_valid, pointer, state and sqrt_busy.
  - req_ready never depends on req_ready.
- Boundary conditions:
  - A requester dropping req_valid before acceptance is legal; no grant is recorded.
  - sqrt_valid seen in IDLE, ISSUE or RESP is ignored (stray strobe after a reset mid-operation).
  - sqrt_busy high in IDLE after a reset blocks all acceptance until it falls.
  - rst asserted in any state: return to IDLE next cycle and drop pending response and latched request without emitting resp_valid.
  - Pointer wrap: after granting NUM_REQ-1, the pointer becomes 0.

Optional Feature:
- Macro: FP_SQRT_ARB_PERF_EN.
- When defined, the block adds three outputs:
  - perf_ops (32): count of completed response handshakes.
  - perf_busy_cycles (32): cycles with state != IDLE.
  - perf_stall_cycles (32): cycles where any req_valid is high but no req_ready is high.
- All counters reset to 0 on rst and saturate at 0xFFFFFFFF.
- When the macro is not defined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Single request: req_valid[0], operand 0x40800000, tag 0x05; stub unit returns 0x40000000 after 6 cycles -> one sqrt_start pulse with sqrt_operand 0x40800000; resp_valid = 0001, resp_result 0x40000000, resp_tag 0x05; accept-to-resp_valid = 8 cycles.
- Round robin: all four req_valid held continuously, pointer 0 -> grants in order 0,1,2,3,0; no requester granted twice before the others are served.
- Backpressure: resp_ready low for 10 cycles in RESP -> resp_valid, resp_result and resp_tag stable; req_ready stays 0; no second sqrt_start.
- Busy interlock: sqrt_busy forced high in IDLE with req_valid[2] high -> req_ready = 0 until sqrt_busy falls, then grant to requester 2.
- Reset mid-operation: rst in WAIT, followed by a stray sqrt_valid 3 cycles later -> no resp_valid; next request issues normally with pointer 0.
- Perf counters (FP_SQRT_ARB_PERF_EN defined): 3 back-to-back ops -> perf_ops = 3; perf_busy_cycles equals summed non-IDLE cycles; stall count matches cycles with requests blocked.

Source files
------------

// File: rtl/fp_sqrt_arbiter_if.sv
// Requester-side bus of the shared FP square-root arbiter: per-requester
// request valid/ready with packed operands and tags, one-hot response with shared result/tag.
interface fp_sqrt_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand;
  logic [NUM_REQ*TAG_W-1:0]      req_tag;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [NUM_REQ-1:0]            resp_ready;
  logic [DATA_WIDTH-1:0]         resp_result;
  logic [TAG_W-1:0]              resp_tag;

  modport master (
    output req_valid, req_operand, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_tag
  );

  modport slave (
    input  req_valid, req_operand, req_tag, resp_ready,
    output req_ready, resp_valid, resp_result, resp_tag
  );
endinterface

// File: rtl/fp_sqrt_arbiter.sv
// Round-robin arbiter sharing one non-pipelined FP sqrt unit among NUM_REQ requesters.
// Optional performance counters are compiled in with FP_SQRT_ARB_PERF_EN.
module fp_sqrt_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_sqrt_arbiter_if.slave      bus,
  output logic                  sqrt_start,
  output logic [DATA_WIDTH-1:0] sqrt_operand,
  input  logic [DATA_WIDTH-1:0] sqrt_result,
  input  logic                  sqrt_valid,
  input  logic                  sqrt_busy
`ifdef FP_SQRT_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                state;
  state_t                state_next;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_found;
  logic [IDX_W:0]        cand;
  logic                  accept_c;
  logic                  resp_done_c;
  logic [NUM_REQ-1:0]    ready_c;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [TAG_W-1:0]      tag_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] operand_arr [NUM_REQ];
  logic [TAG_W-1:0]      tag_arr     [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign operand_arr[i] = bus.req_operand[i*DATA_WIDTH +: DATA_WIDTH];
    assign tag_arr[i]     = bus.req_tag[i*TAG_W +: TAG_W];
  end

  assign bus.req_ready   = ready_c;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_result = result_q;
  assign bus.resp_tag    = tag_q;

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!sel_found && bus.req_valid[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Next state plus the combinational accept path.
  always_comb begin
    state_next  = state;
    ready_c     = '0;
    accept_c    = 1'b0;
    resp_done_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel_found && !sqrt_busy) begin
          ready_c[sel_idx] = 1'b1;
          accept_c         = 1'b1;
          state_next       = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (sqrt_valid) state_next = S_RESP;
      S_RESP: begin
        if (bus.resp_ready[grant_idx]) begin
          resp_done_c = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      grant_idx    <= '0;
      sqrt_operand <= '0;
      tag_q        <= '0;
      result_q     <= '0;
      sqrt_start   <= 1'b0;
      resp_valid   <= '0;
    end else begin
      state      <= state_next;
      sqrt_start <= (state_next == S_ISSUE);
      resp_valid <= (state_next == S_RESP) ? (NUM_REQ'(1) << grant_idx) : '0;
      if (accept_c) begin
        sqrt_operand <= operand_arr[sel_idx];
        tag_q        <= tag_arr[sel_idx];
        grant_idx    <= sel_idx;
        ptr          <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
      end
      // Strobes outside WAIT are leftovers from an aborted operation.
      if (state == S_WAIT && sqrt_valid) result_q <= sqrt_result;
    end
  end

`ifdef FP_SQRT_ARB_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops          <= '0;
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (resp_done_c && perf_ops != '1) perf_ops <= perf_ops + 32'd1;
      if (state != S_IDLE && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((|bus.req_valid) && !(|ready_c) && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Self-checking bench for fp_sqrt_arbiter with a 6-cycle stub sqrt unit.
// Perf counter checks are compiled in with FP_SQRT_ARB_PERF_EN.
module tb_fp_sqrt_arbiter;
  localparam int unsigned LAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sqrt_start;
  logic [31:0] sqrt_operand;
  logic [31:0] sqrt_result;
  logic        sqrt_valid;
  logic        sqrt_busy;
  logic        force_busy  = 1'b0;
  logic        stray_valid = 1'b0;
  int unsigned cnt = 0;
  logic [31:0] stub_res = '0;
`ifdef FP_SQRT_ARB_PERF_EN
  logic [31:0] perf_ops, perf_busy_cycles, perf_stall_cycles;
`endif

  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  logic [31:0] last_sop = '0;
  int          grant_q[$];
  logic [3:0]  granted_mask = '0;

  fp_sqrt_arbiter_if #(.NUM_REQ(4), .TAG_W(6), .DATA_WIDTH(32)) bus ();

  fp_sqrt_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sqrt_start   (sqrt_start),
    .sqrt_operand (sqrt_operand),
    .sqrt_result  (sqrt_result),
    .sqrt_valid   (sqrt_valid),
    .sqrt_busy    (sqrt_busy)
`ifdef FP_SQRT_ARB_PERF_EN
    ,
    .perf_ops          (perf_ops),
    .perf_busy_cycles  (perf_busy_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sqrt_lut(input logic [31:0] x);
    case (x)
      32'h40800000: sqrt_lut = 32'h40000000;
      32'h41800000: sqrt_lut = 32'h40800000;
      32'h41100000: sqrt_lut = 32'h40400000;
      default:      sqrt_lut = ~x;
    endcase
  endfunction

  // Stub unit: not reset by rst, so an aborted operation leaves a stray strobe.
  always @(posedge clk) begin
    if (sqrt_start) begin
      cnt      <= LAT;
      stub_res <= sqrt_lut(sqrt_operand);
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end
  assign sqrt_valid  = (cnt == 1) || stray_valid;
  assign sqrt_busy   = (cnt > 1) || force_busy;
  assign sqrt_result = stub_res;

  always @(posedge clk) begin
    if (sqrt_start) begin
      start_cnt++;
      last_sop = sqrt_operand;
    end
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          grant_q.push_back(i);
          granted_mask[i] = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] mask, output logic [3:0] rr, output int lat,
                        output logic [3:0] rv, output logic [31:0] res, output logic [5:0] tag,
                        output int sdelta, output logic [31:0] sop, output logic [3:0] rv_after);
    int n;
    int s0;
    @(negedge clk);
    bus.req_valid = mask;
    #1;
    rr = bus.req_ready;
    s0 = start_cnt;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.req_valid = '0;
    while (bus.resp_valid == '0 && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    lat    = n;
    rv     = bus.resp_valid;
    res    = bus.resp_result;
    tag    = bus.resp_tag;
    sdelta = start_cnt - s0;
    sop    = last_sop;
    bus.resp_ready = rv;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = '0;
    rv_after = bus.resp_valid;
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          grant;
    logic [31:0] op;
    logic [31:0] res;
    logic [5:0]  tag;
  } vec_t;

  vec_t        vecs[7];
  logic [3:0]  rr, rv, rv_after;
  logic [31:0] res, sop;
  logic [5:0]  tag;
  int          lat, sdelta, bad, s0, n;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Lane i operand/tag; expected result is the stub's answer for that operand.
    vecs[0] = '{4'b0001, 0, 32'h40800000, 32'h40000000, 6'h05};
    vecs[1] = '{4'b1111, 1, 32'h41800000, 32'h40800000, 6'h11};
    vecs[2] = '{4'b1011, 3, 32'h12345678, 32'hEDCBA987, 6'h3F};
    vecs[3] = '{4'b0110, 1, 32'h41800000, 32'h40800000, 6'h11};
    vecs[4] = '{4'b0001, 0, 32'h40800000, 32'h40000000, 6'h05};
    vecs[5] = '{4'b1000, 3, 32'h12345678, 32'hEDCBA987, 6'h3F};
    vecs[6] = '{4'b1111, 0, 32'h40800000, 32'h40000000, 6'h05};

    bus.req_valid   = '0;
    bus.resp_ready  = '0;
    bus.req_operand = {32'h12345678, 32'h41100000, 32'h41800000, 32'h40800000};
    bus.req_tag     = {6'h3F, 6'h22, 6'h11, 6'h05};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_sqrt_start", sqrt_start, 0);
    check("rst_sqrt_operand", sqrt_operand, 0);
    check("rst_resp_result", bus.resp_result, 0);
    check("rst_resp_tag", bus.resp_tag, 0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].mask, rr, lat, rv, res, tag, sdelta, sop, rv_after);
      check($sformatf("vec%0d_req_ready", i), rr, 4'b0001 << vecs[i].grant);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_starts", i), sdelta, 1);
      check($sformatf("vec%0d_sqrt_operand", i), sop, vecs[i].op);
      check($sformatf("vec%0d_resp_valid", i), rv, 4'b0001 << vecs[i].grant);
      check($sformatf("vec%0d_resp_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_resp_tag", i), tag, vecs[i].tag);
      check($sformatf("vec%0d_resp_drop", i), rv_after, 0);
    end

    // Backpressure on lane 2 with other lanes' resp_ready and req_valid active.
    @(negedge clk);
    bus.req_valid = 4'b0100;
    #1;
    check("bp_req_ready", bus.req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    n = 0;
    while (bus.resp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_valid", bus.resp_valid, 4'b0100);
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 4'b1011;
    s0  = start_cnt;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.resp_valid !== 4'b0100 || bus.resp_result !== 32'h40400000 ||
          bus.resp_tag !== 6'h22 || bus.req_ready !== 4'b0000) bad++;
    end
    check("bp_stable_cycles_bad", bad, 0);
    check("bp_no_restart", start_cnt - s0, 0);
    bus.req_valid  = '0;
    bus.resp_ready = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = '0;
    check("bp_resp_drop", bus.resp_valid, 0);

    // Busy interlock: lane 2 blocked while the unit reports busy.
    @(negedge clk);
    force_busy    = 1'b1;
    bus.req_valid = 4'b0100;
    bad = 0;
    repeat (5) begin
      #1;
      if (bus.req_ready !== 4'b0000) bad++;
      @(negedge clk);
    end
    check("busy_block_bad", bad, 0);
    force_busy    = 1'b0;
    bus.req_valid = '0;
    run_op(4'b0100, rr, lat, rv, res, tag, sdelta, sop, rv_after);
    check("busy_release_ready", rr, 4'b0100);
    check("busy_release_result", res, 32'h40400000);

    // Reset while waiting on the unit, then stray strobes.
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0010;
    #1;
    check("rstmid_req_ready", bus.req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    s0  = start_cnt;
    bad = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      stray_valid = (c == 2);
      if (bus.resp_valid !== 4'b0000) bad++;
    end
    stray_valid = 1'b0;
    check("rstmid_no_resp_cycles", bad, 0);
    check("rstmid_no_start", start_cnt - s0, 0);
    run_op(4'b1111, rr, lat, rv, res, tag, sdelta, sop, rv_after);
    check("rstmid_next_grant", rr, 4'b0001);
    check("rstmid_next_latency", lat, 8);
    check("rstmid_next_result", res, 32'h40000000);
    check("rstmid_next_tag", tag, 6'h05);

    // Round robin with all lanes continuously requesting.
    do_reset();
    grant_q.delete();
    bus.resp_ready = '1;
    bus.req_valid  = '1;
    n = 0;
    while (grant_q.size() < 5 && n < 80) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid = '0;
    repeat (12) @(negedge clk);
    bus.resp_ready = '0;
    check("rr_grant_count", grant_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_q.size()) check($sformatf("rr_grant%0d", i), grant_q[i], i % 4);
    end

`ifdef FP_SQRT_ARB_PERF_EN
    // Three back-to-back ops; each granted lane withdraws its request.
    do_reset();
    granted_mask   = '0;
    bus.resp_ready = '1;
    @(negedge clk);
    bus.req_valid = 4'b0111;
    repeat (40) begin
      @(negedge clk);
      bus.req_valid = bus.req_valid & ~granted_mask;
    end
    bus.resp_ready = '0;
    check("perf_ops", perf_ops, 3);
    check("perf_busy_cycles", perf_busy_cycles, 24);
    check("perf_stall_cycles", perf_stall_cycles, 16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
